// File: rtl/ena_burst_gen.sv
// rtl/ena_burst_gen.sv - burst enable sequencer for the event counter; optional ENA_BURST_ISSUED_EN adds the issued counter
module ena_burst_gen #(
    parameter int LEN_W = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LEN_W-1:0] req_len,
    input  logic [DIV_W-1:0] req_div,
    input  logic             abort,
    output logic             ena,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [LEN_W-1:0] issued
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] spc_q;
    logic             hs;
    logic             last_pulse;

    assign req_ready = (state == IDLE);
    assign hs        = req_valid && req_ready;

`ifdef ENA_BURST_ISSUED_EN
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;

    // The pulse currently on ena is the last one when it brings the count up to len.
    assign last_pulse = ((cnt_q + LEN_W'(1)) == len_q);
    assign issued     = cnt_q;

    // Issued counter: cleared on handshake, counts every cycle ena was high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            len_q <= '0;
            cnt_q <= '0;
        end else if (hs) begin
            len_q <= req_len;
            cnt_q <= '0;
        end else if (state == RUN && ena) begin
            cnt_q <= cnt_q + LEN_W'(1);
        end
    end
`else
    logic [LEN_W-1:0] rem_q;

    // Remaining pulses including the one currently on ena.
    assign last_pulse = (rem_q == LEN_W'(1));
    assign issued     = '0;

    // Down-counter on the latched length, decremented per issued pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rem_q <= '0;
        end else if (hs) begin
            rem_q <= req_len;
        end else if (state == RUN && ena) begin
            rem_q <= rem_q - LEN_W'(1);
        end
    end
`endif

    // Burst FSM; ena/busy/done are registered as the value for the next cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            ena     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            div_q   <= '0;
            spc_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (hs) begin
                        div_q   <= req_div;
                        spc_q   <= '0;
                        aborted <= 1'b0;
                        if (req_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            ena   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        // A pulse scheduled for the next cycle is dropped.
                        state   <= DONE;
                        ena     <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (ena) begin
                        if (last_pulse) begin
                            state <= DONE;
                            ena   <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            spc_q <= div_q;
                            ena   <= (div_q == '0);
                        end
                    end else begin
                        spc_q <= spc_q - DIV_W'(1);
                        ena   <= (spc_q == DIV_W'(1));
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ena   <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
